// File: rtl/cv32e40p_trace_buffer.sv
// Retirement trace capture FIFO: packs retired instructions into sequenced records and never stalls the core.
// Optional per-record cycle timestamp is enabled by defining CV32E40P_TRACE_TIMESTAMP_EN.
module cv32e40p_trace_buffer #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned SEQ_WIDTH      = 16,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          flush_i,
    input  logic [NUM_PORTS-1:0]          ret_valid_i,
    input  logic [NUM_PORTS*32-1:0]       ret_pc_i,
    input  logic [NUM_PORTS*32-1:0]       ret_instr_i,
    input  logic [NUM_PORTS-1:0]          ret_rd_we_i,
    input  logic [NUM_PORTS*6-1:0]        ret_rd_addr_i,
    input  logic [NUM_PORTS*32-1:0]       ret_rd_wdata_i,
    output logic                          trc_valid_o,
    input  logic                          trc_ready_i,
    output logic [31:0]                   trc_pc_o,
    output logic [31:0]                   trc_instr_o,
    output logic [31:0]                   trc_rd_wdata_o,
    output logic                          trc_rd_we_o,
    output logic [5:0]                    trc_rd_addr_o,
    output logic [SEQ_WIDTH-1:0]          trc_seq_o,
    output logic                          trc_lost_o,
    output logic [31:0]                   trc_ts_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic [DROP_CNT_WIDTH-1:0]     drop_cnt_o
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned DW1 = DROP_CNT_WIDTH + 1;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic                 rd_we;
        logic [5:0]           rd_addr;
        logic [31:0]          rd_wdata;
        logic [SEQ_WIDTH-1:0] seq;
        logic                 lost;
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
        logic [31:0]          ts;
`endif
    } rec_t;

    rec_t                      mem_q [DEPTH];
    rec_t                      mem_d [DEPTH];
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [SEQ_WIDTH-1:0]      seq_q, seq_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      lost_pending_q, lost_pending_d;
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
    logic [31:0]               ts_q, ts_d;
`endif

    logic                      pop;
    rec_t                      head;
    rec_t                      rec;
    logic                      pend;
    logic [AW-1:0]             base_wr;
    logic [DW1-1:0]            drop_sum;
    int unsigned               free_slots;
    int unsigned               n_acc;
    int unsigned               n_drop;
    int unsigned               n_val;

    assign trc_valid_o = (count_q != '0);
    // A flush discards the head, so a same-cycle handshake is not a pop.
    assign pop         = trc_valid_o & trc_ready_i & ~flush_i;

    // NOTE: blocking assignments in always_comb, every target defaulted first so no latch is
    // inferred; each port's slot depends on how many earlier ports were already placed this cycle.
    always_comb begin
        mem_d      = mem_q;
        rec        = '0;
        n_acc      = 0;
        n_drop     = 0;
        n_val      = 0;
        pend       = flush_i ? 1'b0 : lost_pending_q;
        base_wr    = flush_i ? '0 : wr_ptr_q;
        free_slots = flush_i ? DEPTH : (DEPTH - 32'(count_q) + 32'(pop));

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (enable_i && ret_valid_i[p]) begin
                rec          = '0;
                rec.pc       = ret_pc_i[p*32 +: 32];
                rec.instr    = ret_instr_i[p*32 +: 32];
                rec.rd_we    = ret_rd_we_i[p];
                rec.rd_addr  = ret_rd_addr_i[p*6 +: 6];
                rec.rd_wdata = ret_rd_wdata_i[p*32 +: 32];
                rec.seq      = seq_q + SEQ_WIDTH'(n_val);
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
                rec.ts       = ts_q;
`endif
                n_val++;
                if (n_acc < free_slots) begin
                    rec.lost = pend;
                    pend     = 1'b0;
                    mem_d[base_wr + AW'(n_acc)] = rec;
                    n_acc++;
                end else begin
                    n_drop++;
                    pend = 1'b1;
                end
            end
        end

        wr_ptr_d       = base_wr + AW'(n_acc);
        rd_ptr_d       = flush_i ? '0 : (rd_ptr_q + AW'(pop));
        count_d        = flush_i ? CW'(n_acc) : (count_q - CW'(pop) + CW'(n_acc));
        seq_d          = seq_q + SEQ_WIDTH'(n_val);
        lost_pending_d = pend;

        drop_sum   = {1'b0, drop_cnt_q} + DW1'(n_drop);
        drop_cnt_d = drop_sum[DW1-1] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    end

`ifdef CV32E40P_TRACE_TIMESTAMP_EN
    assign ts_d = ts_q + 32'd1;
`endif

    // NOTE: state flops use non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            seq_q          <= '0;
            drop_cnt_q     <= '0;
            lost_pending_q <= 1'b0;
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
            ts_q           <= '0;
`endif
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            seq_q          <= seq_d;
            drop_cnt_q     <= drop_cnt_d;
            lost_pending_q <= lost_pending_d;
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
            ts_q           <= ts_d;
`endif
        end
    end

    // NOTE: record storage has no reset; count_q gates visibility so stale entries are never seen.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_q <= mem_d;
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign trc_pc_o       = head.pc;
    assign trc_instr_o    = head.instr;
    assign trc_rd_we_o    = head.rd_we;
    assign trc_rd_addr_o  = head.rd_addr;
    assign trc_rd_wdata_o = head.rd_wdata;
    assign trc_seq_o      = head.seq;
    assign trc_lost_o     = head.lost;
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
    assign trc_ts_o       = head.ts;
`else
    assign trc_ts_o       = '0;
`endif
    assign count_o        = count_q;
    assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: doc/cv32e40p_trace_buffer.md
Name: cv32e40p_trace_buffer

Overview:
- Multi-port retirement trace capture buffer that sits beside the core inside the wrapper and observes retired instructions non-intrusively.
- Packs each retirement (pc, instr, rd write) into a record with a sequence number and pushes it into a parametrised FIFO.
- A downstream logger or debug port drains the FIFO over a valid/ready interface.
- Never back-pressures the core: on overflow, records are dropped, counted, and flagged.

Parameters:
- NUM_PORTS, 2, retirement channels sampled per cycle (1..4); port 0 is oldest in program order.
- DEPTH, 16, record FIFO entries; power of 2, >= NUM_PORTS.
- SEQ_WIDTH, 16, sequence number width.
- DROP_CNT_WIDTH, 16, saturating drop counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- enable_i  in  1  capture enable
- flush_i  in  1  discard all buffered records
- ret_valid_i  in  NUM_PORTS  retirement valid per port
- ret_pc_i  in  NUM_PORTS*32  retired pc
- ret_instr_i  in  NUM_PORTS*32  retired instruction word
- ret_rd_we_i  in  NUM_PORTS  register write enable
- ret_rd_addr_i  in  NUM_PORTS*6  destination register (bit 5 = fp regfile)
- ret_rd_wdata_i  in  NUM_PORTS*32  write data
- trc_valid_o  out  1  head record valid
- trc_ready_i  in  1  consumer accepts head
- trc_pc_o / trc_instr_o / trc_rd_wdata_o  out  32 each  head record fields
- trc_rd_we_o  out  1, trc_rd_addr_o  out  6  head record fields
- trc_seq_o  out  SEQ_WIDTH  record sequence number
- trc_lost_o  out  1  one or more records were dropped before this one
- trc_ts_o  out  32  timestamp (see Optional Feature)
- count_o  out  $clog2(DEPTH)+1  occupied entries
- drop_cnt_o  out  DROP_CNT_WIDTH  total dropped records, saturating

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - Pointers, count_o, seq counter, drop_cnt_o, lost_pending and timestamp are all cleared to 0.
  - trc_valid_o=0.
  - rst_i overrides every other input in that cycle.
- Pop: occurs when trc_valid_o & trc_ready_i.
  - trc_valid_o = (count_o != 0).
  - Head fields are driven combinationally from storage.
  - Head fields are don't-care when trc_valid_o=0.
- Push:
  - Only when enable_i=1. With enable_i=0, ret_* inputs are ignored: no push, no seq increment, no drop.
  - n = number of set ret_valid_i bits.
  - free = DEPTH - count_o + pop; a same-cycle pop frees a slot.
  - Accept the lowest-indexed min(n, free) valid ports, written in port order. The remaining valid ports are dropped.
- Latency: a record accepted in cycle t is visible at the head in cycle t+1 if the FIFO was empty.
- Sequence numbering:
  - Every valid retirement (accepted or dropped) consumes one sequence number, assigned in port order.
  - The counter wraps modulo 2^SEQ_WIDTH, so gaps reveal drops.
- Drops:
  - drop_cnt_o increases by the number dropped per cycle and saturates at all-ones.
  - Any drop sets lost_pending.
  - The next accepted record stores lost=1. This can be a record in a later cycle, or the first accepted record in the same cycle whose port index is above a dropped port; the latter cannot occur under lowest-first acceptance, so in practice lost lands on the next cycle's first accepted record.
  - Storing lost=1 clears lost_pending.
- Flush (flush_i=1):
  - Contents are discarded and count becomes 0 at the next edge. Any same-cycle pop is ignored.
  - Same-cycle retirements are written into the emptied FIFO, with free=DEPTH.
  - Flush clears lost_pending. It does not change drop_cnt_o or the seq counter.
- Full with simultaneous pop and push: the pop slot is reused. count_o stays DEPTH and nothing is dropped.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. count_o is tracked explicitly.

Optional Feature:
- Macro: CV32E40P_TRACE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter runs from reset and wraps.
  - Each accepted record stores the counter value of its push cycle in trc_ts_o.
  - All records accepted in one cycle share that value.
- Undefined: no counter and no storage; trc_ts_o is tied to 0.

Test Plan:
- Reset, enable_i=1, port0 retires pc=0x80, instr=0x00500093, rd=1, wdata=5 -> next cycle trc_valid_o=1 with those fields, seq=0, lost=0, count_o=1.
- NUM_PORTS=2, both ports valid for 8 cycles, trc_ready_i=0, DEPTH=16 -> count_o=16, drop_cnt_o=0. A 9th dual retirement -> drop_cnt_o=2, count_o=16.
- From the full state above, drain one record while both ports retire -> port0 accepted (seq=18), port1 dropped (drop_cnt_o=3). The next accepted record has lost=1 and seq=20.
- Full FIFO, trc_ready_i=1 every cycle, one retirement per cycle -> count_o stays 16, no drops, seq contiguous.
- flush_i=1 with count_o=10 and one same-cycle retirement -> count_o=1, head is the new record, drop_cnt_o unchanged.
- With CV32E40P_TRACE_TIMESTAMP_EN, retire at cycles 3 and 7 after reset -> trc_ts_o=3, then 7. Without the macro, trc_ts_o=0.
